// File: rtl/mips_mem_loader.sv
// Byte-stream boot loader: frames of CMD/CNT/ADR/words drive im/dm/regfile write ports.
// Optional trailing frame checksum byte when MIPS_LOADER_CHECKSUM_EN is defined.
module mips_mem_loader #(
  parameter int ADDR_W     = 16,
  parameter int REG_ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [7:0]        i_in_byte,
  output logic              o_wr_en,
  output logic [1:0]        o_wr_target,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_load_err
);

`ifdef MIPS_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_CMD, S_CNT_H, S_CNT_L, S_ADR_H, S_ADR_L, S_DATA, S_CKSUM, S_RUN, S_ERROR
  } state_t;
  localparam state_t S_FRAME_END = S_CKSUM;
`else
  typedef enum logic [3:0] {
    S_CMD, S_CNT_H, S_CNT_L, S_ADR_H, S_ADR_L, S_DATA, S_RUN, S_ERROR
  } state_t;
  localparam state_t S_FRAME_END = S_CMD;
`endif

  state_t              r_state, w_next;
  logic [1:0]          r_target;
  logic [15:0]         r_cnt;
  logic [7:0]          r_adr_h;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_asm;
  logic                r_wr_en;
  logic [1:0]          r_wr_target;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [7:0]          r_cksum;
`endif
  logic                w_load_state;
  logic                w_fire;
  logic                w_reg_oob;
  logic                w_word_done;

  always_comb begin
    w_load_state = 1'b0;
    case (r_state)
      S_CMD, S_CNT_H, S_CNT_L, S_ADR_H, S_ADR_L, S_DATA: w_load_state = 1'b1;
`ifdef MIPS_LOADER_CHECKSUM_EN
      S_CKSUM: w_load_state = 1'b1;
`endif
      default: w_load_state = 1'b0;
    endcase
  end

  // Gate with rst_n so in_ready is low throughout reset yet high right after release.
  assign o_in_ready  = rst_n & w_load_state;
  assign w_fire      = i_in_valid & o_in_ready;
  assign w_reg_oob   = (r_target == 2'd3) && ((r_addr >> REG_ADDR_W) != '0);
  assign w_word_done = w_fire && (r_state == S_DATA) && (r_bcnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CMD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CMD: if (w_fire) begin
        if (i_in_byte == 8'h01 || i_in_byte == 8'h02 || i_in_byte == 8'h03) w_next = S_CNT_H;
        else if (i_in_byte == 8'hFF)                                         w_next = S_RUN;
        else                                                                 w_next = S_ERROR;
      end
      S_CNT_H: if (w_fire) w_next = S_CNT_L;
      S_CNT_L: if (w_fire) w_next = S_ADR_H;
      S_ADR_H: if (w_fire) w_next = S_ADR_L;
      S_ADR_L: if (w_fire) w_next = (r_cnt == 16'd0) ? S_FRAME_END : S_DATA;
      S_DATA: if (w_word_done) begin
        if (w_reg_oob)              w_next = S_ERROR;
        else if (r_cnt == 16'd1)    w_next = S_FRAME_END;
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      S_CKSUM: if (w_fire) w_next = (i_in_byte == r_cksum) ? S_CMD : S_ERROR;
`endif
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target    <= '0;
      r_cnt       <= '0;
      r_adr_h     <= '0;
      r_addr      <= '0;
      r_bcnt      <= '0;
      r_asm       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_target <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      r_cksum     <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_fire) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
        r_cksum <= (r_state == S_CMD) ? i_in_byte : (r_cksum ^ i_in_byte);
`endif
        case (r_state)
          S_CMD:   r_target     <= i_in_byte[1:0];
          S_CNT_H: r_cnt[15:8]  <= i_in_byte;
          S_CNT_L: r_cnt[7:0]   <= i_in_byte;
          S_ADR_H: r_adr_h      <= i_in_byte;
          S_ADR_L: begin
            r_addr <= ADDR_W'({r_adr_h, i_in_byte});
            r_bcnt <= 2'd0;
          end
          S_DATA: begin
            r_bcnt <= r_bcnt + 2'd1;
            r_asm  <= {r_asm[15:0], i_in_byte};
            // Out-of-range register index: drop this word, FSM moves to ERROR.
            if (r_bcnt == 2'd3 && !w_reg_oob) begin
              r_wr_en     <= 1'b1;
              r_wr_target <= r_target;
              r_wr_addr   <= r_addr;
              r_wr_data   <= {r_asm, i_in_byte};
              r_addr      <= r_addr + ADDR_W'(1);
              r_cnt       <= r_cnt - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_target = r_wr_target;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_cpu_hold  = (r_state != S_RUN);
  assign o_load_err  = (r_state == S_ERROR);

endmodule
